// File: rtl/simple_axi_write_arbiter.sv
// simple_axi_write_arbiter
// Round-robin arbiter sharing one simple-AXI write port between N_MASTERS
// requesters. A grant is held from request until the final data-word
// handshake with last. A one-cycle RELEASE gap separates transactions.
// The data path is purely combinational: zero added latency, no buffering.
module simple_axi_write_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [N_MASTERS-1:0]                  s_wvalid_i,
    output logic [N_MASTERS-1:0]                  s_wready_o,
    input  logic [N_MASTERS*AXI_ADDR_W-1:0]       s_waddr_i,
    input  logic [N_MASTERS*AXI_DATA_W-1:0]       s_wdata_i,
    input  logic [(N_MASTERS*AXI_DATA_W/8)-1:0]   s_wstrb_i,
    input  logic [N_MASTERS*LEN_W-1:0]            s_wlen_i,
    output logic [N_MASTERS-1:0]                  s_wlast_o,
    output logic                                  m_wvalid_o,
    input  logic                                  m_wready_i,
    output logic [AXI_ADDR_W-1:0]                 m_waddr_o,
    output logic [AXI_DATA_W-1:0]                 m_wdata_o,
    output logic [(AXI_DATA_W/8)-1:0]             m_wstrb_o,
    output logic [LEN_W-1:0]                      m_wlen_o,
    input  logic                                  m_wlast_i,
    output logic [N_MASTERS-1:0]                  grant_o,
    output logic                                  busy_o
);

    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int PTR_W  = $clog2(N_MASTERS);
    // One extra bit so rr_ptr + offset can exceed N_MASTERS-1 before the wrap.
    localparam int IDX_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N_MASTERS-1:0]   r_grant;
    logic [N_MASTERS-1:0]   w_grant_nxt;
    logic [PTR_W-1:0]       r_gidx;
    logic [PTR_W-1:0]       w_gidx_nxt;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       w_rr_ptr_nxt;
    logic [PTR_W-1:0]       w_win_idx;
    logic                   w_win_found;
    logic [IDX_W-1:0]       w_scan_idx;
    logic                   w_txn_end;

    // Winner search: first valid requester from rr_ptr upward, wrapping explicitly
    // so a non-power-of-2 N_MASTERS never selects a nonexistent requester.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise
        // paths that skip an assignment infer a latch.
        w_win_idx   = '0;
        w_win_found = 1'b0;
        w_scan_idx  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_scan_idx = {1'b0, r_rr_ptr} + IDX_W'(i);
            if (w_scan_idx >= IDX_W'(N_MASTERS)) begin
                w_scan_idx = w_scan_idx - IDX_W'(N_MASTERS);
            end
            if (!w_win_found && s_wvalid_i[w_scan_idx[PTR_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan_idx[PTR_W-1:0];
            end
        end
    end

    // Data path: in GRANT the master port is a straight mux of the owner's slice.
    always_comb begin
        m_wvalid_o = 1'b0;
        m_waddr_o  = '0;
        m_wdata_o  = '0;
        m_wstrb_o  = '0;
        m_wlen_o   = '0;
        s_wready_o = '0;
        s_wlast_o  = '0;
        if (r_state == S_GRANT) begin
            m_wvalid_o         = s_wvalid_i[r_gidx];
            m_waddr_o          = s_waddr_i[r_gidx*AXI_ADDR_W +: AXI_ADDR_W];
            m_wdata_o          = s_wdata_i[r_gidx*AXI_DATA_W +: AXI_DATA_W];
            m_wstrb_o          = s_wstrb_i[r_gidx*STRB_W +: STRB_W];
            m_wlen_o           = s_wlen_i[r_gidx*LEN_W +: LEN_W];
            s_wready_o[r_gidx] = m_wready_i;
            s_wlast_o[r_gidx]  = m_wlast_i;
        end
    end

    assign w_txn_end = m_wvalid_o & m_wready_i & m_wlast_i;

    // Next-state logic: grant on any request in IDLE, release on the last handshake.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_gidx_nxt   = r_gidx;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt            = S_GRANT;
                    w_grant_nxt            = '0;
                    w_grant_nxt[w_win_idx] = 1'b1;
                    w_gidx_nxt             = w_win_idx;
                end
            end
            S_GRANT: begin
                if (w_txn_end) begin
                    w_state_nxt  = S_RELEASE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = (r_gidx == PTR_W'(N_MASTERS - 1)) ? '0 : r_gidx + PTR_W'(1);
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, grant and pointer registers; reset clears the grant immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign grant_o = r_grant;
    assign busy_o  = (r_state != S_IDLE);

endmodule
